// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the sequential multiplier.
// Booth pair encodings are used only when SEQ_MUL_SIGNED_EN is defined.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SEQ_MUL_N = 8;

    // Booth pair {Q[0], q_1}
    localparam logic [1:0] BOOTH_NOP_LO = 2'b00;
    localparam logic [1:0] BOOTH_ADD    = 2'b01;
    localparam logic [1:0] BOOTH_SUB    = 2'b10;
    localparam logic [1:0] BOOTH_NOP_HI = 2'b11;

endpackage

// File: rtl/seq_mul_step.sv
// One combinational multiply iteration: add/sub into ACC, then shift {ACC, Q, q_1}.
// SEQ_MUL_SIGNED_EN selects radix-2 Booth (signed); otherwise unsigned shift-add.
module seq_mul_step
    import seq_mul_pkg::*;
#(
    parameter int N = SEQ_MUL_N
) (
    input  logic [N:0]   acc,
    input  logic [N-1:0] q,
    input  logic         q_1,
    input  logic [N-1:0] m,
    output logic [N:0]   acc_next,
    output logic [N-1:0] q_next,
    output logic         q_1_next
);

    logic [N:0] sum;

`ifdef SEQ_MUL_SIGNED_EN
    logic [N:0] m_ext;

    always_comb begin
        m_ext = {m[N-1], m};
        case ({q[0], q_1})
            BOOTH_ADD: sum = acc + m_ext;
            BOOTH_SUB: sum = acc - m_ext;
            default:   sum = acc;
        endcase
        // Arithmetic shift of {sum, q, q_1}: replicate sum[N], q[0] drops into q_1
        {acc_next, q_next, q_1_next} = {sum[N], sum, q};
    end
`else
    always_comb begin
        sum = q[0] ? ({1'b0, acc[N-1:0]} + {1'b0, m}) : acc;
        {acc_next, q_next} = {1'b0, sum, q[N-1:1]};
        q_1_next = q_1 & 1'b0;
    end
`endif

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle NxN multiplier with start/ready/done handshake; N iterations per product.
// Build option SEQ_MUL_SIGNED_EN (applied inside seq_mul_step) selects signed Booth.
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int N = SEQ_MUL_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);

    state_t         state, state_next;
    logic [N-1:0]   m_reg, q_reg;
    logic [N:0]     acc_reg;
    logic           q_1_reg;
    logic [CW-1:0]  cnt;

    logic [N:0]     acc_step;
    logic [N-1:0]   q_step;
    logic           q_1_step;

    seq_mul_step #(.N(N)) step (
        .acc      (acc_reg),
        .q        (q_reg),
        .q_1      (q_1_reg),
        .m        (m_reg),
        .acc_next (acc_step),
        .q_next   (q_step),
        .q_1_next (q_1_step)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            // cnt==1 here means this edge performs the final iteration
            CALC:    if (cnt == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_reg   <= '0;
            q_reg   <= '0;
            acc_reg <= '0;
            q_1_reg <= 1'b0;
            cnt     <= '0;
        end else if (state == IDLE && start) begin
            m_reg   <= a;
            q_reg   <= b;
            acc_reg <= '0;
            q_1_reg <= 1'b0;
            cnt     <= CW'(N);
        end else if (state == CALC) begin
            acc_reg <= acc_step;
            q_reg   <= q_step;
            q_1_reg <= q_1_step;
            cnt     <= cnt - CW'(1);
        end
    end

    assign ready   = (state == IDLE);
    assign done    = (state == DONE);
    assign product = {acc_reg[N-1:0], q_reg};

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier; reference product computed with plain integer multiply.
// Compile with SEQ_MUL_SIGNED_EN to check the signed build.
module tb_seq_multiplier;
    import seq_mul_pkg::*;

    localparam int N = SEQ_MUL_N;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   a, b;
    logic           ready, done;
    logic [2*N-1:0] product;

    int tests = 0;
    int fails = 0;

    seq_multiplier #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
        longint px;
`ifdef SEQ_MUL_SIGNED_EN
        px = longint'($signed(x)) * longint'($signed(y));
`else
        px = longint'(x) * longint'(y);
`endif
        return px[2*N-1:0];
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after ready comes back.
    task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y,
                          input bit hold, input logic [2*N-1:0] exp, input string tag);
        int done_cnt;
        int first_done;
        int ready_bad;
        logic [2*N-1:0] prod_done;
        done_cnt   = 0;
        first_done = -1;
        ready_bad  = 0;
        prod_done  = '0;
        tests++;
        if (ready !== 1'b1) begin
            fails++;
            $display("FAIL %s ready_before_accept: got %b want 1", tag, ready);
        end
        start = 1'b1;
        a = x;
        b = y;
        @(posedge clk);
        for (int k = 0; k <= N + 1; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (!hold) begin
                a = N'($urandom);
                b = N'($urandom);
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = k;
                    prod_done  = product;
                end
            end
            if (k <= N && ready !== 1'b0) ready_bad++;
        end
        tests++;
        if (first_done != N) begin
            fails++;
            $display("FAIL %s done_latency: got %0d want %0d", tag, first_done, N);
        end
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL %s done_pulses: got %0d want 1", tag, done_cnt);
        end
        tests++;
        if (prod_done !== exp) begin
            fails++;
            $display("FAIL %s product: a=%h b=%h got %h want %h", tag, x, y, prod_done, exp);
        end
        tests++;
        if (product !== exp) begin
            fails++;
            $display("FAIL %s product_hold: got %h want %h", tag, product, exp);
        end
        tests++;
        if (ready_bad != 0) begin
            fails++;
            $display("FAIL %s ready_busy: %0d cycles with ready high, want 0", tag, ready_bad);
        end
        tests++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL %s ready_return: got ready=%b done=%b want 1/0", tag, ready, done);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (ready !== 1'b1 || done !== 1'b0 || product !== '0) begin
            fails++;
            $display("FAIL reset_state: got ready=%b done=%b product=%h want 1/0/0", ready, done, product);
        end
    endtask

    task automatic test_directed();
`ifdef SEQ_MUL_SIGNED_EN
        run_op(8'hFD, 8'h05, 1'b0, 16'hFFF1, "signed_m3x5");
        run_op(8'h80, 8'h80, 1'b0, 16'h4000, "signed_min_sq");
        run_op(8'h7F, 8'h80, 1'b0, 16'hC080, "signed_max_min");
        run_op(8'hFF, 8'hFF, 1'b0, 16'h0001, "signed_m1_sq");
`else
        run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, "unsigned_ff_sq");
        run_op(8'h00, 8'hA5, 1'b0, 16'h0000, "unsigned_zero");
        run_op(8'hA5, 8'h01, 1'b0, 16'h00A5, "unsigned_one");
        run_op(8'h80, 8'h80, 1'b0, 16'h4000, "unsigned_80_sq");
`endif
    endtask

    task automatic test_start_held();
        logic [N-1:0] x;
        logic [N-1:0] y;
        x = N'($urandom);
        y = N'($urandom);
        run_op(x, y, 1'b1, ref_mul(x, y), "start_held");
        // start still high: the second accept must land on the next edge, not earlier
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (ready !== 1'b0) begin
            fails++;
            $display("FAIL start_held_second_accept: got ready=%b want 0", ready);
        end
        repeat (N + 1) @(negedge clk);
        tests++;
        if (ready !== 1'b1) begin
            fails++;
            $display("FAIL start_held_drain: got ready=%b want 1", ready);
        end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        done_seen = 0;
        start = 1'b1;
        a = N'($urandom_range(1, 255));
        b = N'($urandom_range(1, 255));
        @(posedge clk);
        for (int k = 0; k <= N + 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 3) rst = 1'b1;
            if (k == 4) begin
                rst = 1'b0;
                tests++;
                if (ready !== 1'b1 || done !== 1'b0 || product !== '0) begin
                    fails++;
                    $display("FAIL reset_mid_state: got ready=%b done=%b product=%h want 1/0/0",
                             ready, done, product);
                end
            end
            if (done === 1'b1) done_seen++;
        end
        tests++;
        if (done_seen != 0) begin
            fails++;
            $display("FAIL reset_mid_no_done: got %0d done pulses want 0", done_seen);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] x;
        logic [N-1:0] y;
        for (int i = 0; i < 1000; i++) begin
            x = N'($urandom);
            y = N'($urandom);
            if (i % 50 == 0) x = '0;
            if (i % 50 == 1) y = '1;
            run_op(x, y, 1'b0, ref_mul(x, y), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_held();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Multi-cycle N×N integer multiplier with a start/done handshake, producing a 2N-bit product over N iteration cycles. It is the multiplication counterpart to the team's sequential shift-and-subtract divider datapath and uses the same building blocks: add/sub unit, loadable shift register and down-counter. A controller drives it like any other CA1 arithmetic unit: assert `start` while `ready`, then wait for the `done` pulse.

## Interface
- `N`, default 8: operand width in bits; legal for N ≥ 2.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: request; sampled only in IDLE.
- `a`  in  N: multiplicand; captured on the accepting edge.
- `b`  in  N: multiplier; captured on the accepting edge.
- `ready`  out  1: high exactly when state = IDLE.
- `done`  out  1: one-cycle pulse marking the product as final.
- `product`  out  2N: result; holds its value until the next accepted start.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE→CALC on `start`.
  - CALC→DONE when the iteration count reaches 0.
  - DONE→IDLE unconditionally.
- Internal registers:
  - `M` (N bits)
  - `ACC` (N+1 bits; the extra bit absorbs carry and sign)
  - `Q` (N bits)
  - `q_1` (1 bit)
  - `cnt` ($clog2(N+1) bits)
- Accept (IDLE and `start`): `M`←a, `Q`←b, `ACC`←0, `q_1`←0, `cnt`←N.
- Each CALC cycle performs one iteration, then `cnt`←cnt−1. The iteration depends on the configuration (see Configuration).
- Result: `product` = {ACC[N−1:0], Q}. It is driven from the registers continuously, so its value during CALC is a partial result. It is valid from DONE until the next accept.
- `start` in CALC or DONE is ignored, with no queuing. A new operation requires a fresh `start` in IDLE.
- Overflow cannot occur: the full 2N-bit product always fits.

## Timing
- Reset: state IDLE, `ready`=1, `done`=0, `product`=0 (ACC, Q, M, q_1, cnt cleared).
- Reset mid-operation aborts on that edge; the partial result is discarded.
- `rst` has priority over `start` on the same edge.
- Let start be accepted at edge t0:
  - `ready`=0 from t0.
  - N iterations occur at edges t0+1 … t0+N.
  - State = DONE after edge t0+N, so `done`=1 for the cycle between edges t0+N and t0+N+1.
  - `ready`=1 again after edge t0+N+1.
- Earliest back-to-back accept is edge t0+N+2. Throughput is one result per N+2 cycles.
- `ready` and `done` are decoded from the state register. There are no combinational paths from inputs to outputs.

## Configuration
- Macro `SEQ_MUL_SIGNED_EN`.
- Defined: operands are two's complement and the block uses radix-2 Booth. On `{Q[0], q_1}`:
  - 01: `ACC` += sext(M)
  - 10: `ACC` −= sext(M)
  - 00 / 11: no change
  - Then arithmetic right shift of {ACC, Q, q_1} by one, replicating ACC[N].
- Undefined: operands are unsigned and the block uses shift-add.
  - If Q[0]=1, `ACC` = {0, ACC[N−1:0]} + M, with the carry landing in ACC[N].
  - Then logical right shift of {ACC, Q} by one, shifting in 0.
  - `q_1` is unused and held at 0.
- Interface, latency and handshake are identical in both builds.

## Structure
- Package `seq_mul_pkg` holds:
  - `typedef enum` for the state type (IDLE/CALC/DONE)
  - default width constant `SEQ_MUL_N = 8`
  - the encoding constants for the Booth pair `{Q[0], q_1}`
- Sub-module `seq_mul_step` is combinational. It takes ACC, Q, q_1 and M and returns the next ACC, Q and q_1 for one iteration; the configuration macro is applied only here.
- The top level holds the FSM, counter and registers.

## Test plan
- Signed build, N=8, a=−3 (8'hFD), b=5: `done` after exactly 9 edges (at edge t0+8 counting from accept), product=16'hFFF1 (−15).
- Signed build, a=b=8'h80 (−128): product=16'h4000. Also a=8'h7F, b=8'h80: product=16'hC080 (−16256).
- Unsigned build, a=b=8'hFF: product=16'hFE01. Also a=0, b=8'hA5: product=0.
- `start` held high through the whole operation: exactly one `done` pulse; a second operation is accepted only at edge t0+10; `ready` sequence is 1,0…0,1.
- Assert `rst` at edge t0+4 of an operation: next cycle has `ready`=1, `done`=0, product=0, and no `done` pulse follows.
- Random 1000 operand pairs per build against a reference multiply: bit-exact product, and `done` is never asserted outside DONE.
